// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for apb_uart.
//   Register offsets (word index taken from paddr[3:2]), STATUS and CTRL
//   bit positions, and the TX/RX state encodings.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_RX_OVR   = 3;
  localparam int ST_TX_BUSY  = 4;

  localparam int CTRL_TX_IE   = 0;
  localparam int CTRL_RX_IE   = 1;
  localparam int CTRL_CLR_OVR = 2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, wdata     write request and data (accepted when not full, or when popping)
//   pop, rdata      read request; rdata shows the head entry
//   full, empty     status flags
module uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/apb_uart.sv
// apb_uart: APB slave 8N1 UART with TX FIFO and one-byte RX holding register.
// Ports:
//   APB_PCLK, APB_PRESET        clock, synchronous active-high reset
//   APB_paddr/pdata/psel/penable/pwrite/pstb   APB request
//   APB_prdata/pready/perr      APB response (pready stalls DATA writes when TX FIFO full)
//   uart_txd, uart_rxd          serial lines (idle high; rxd asynchronous)
//   interrupt                   (tx_empty & TX_IE) | (rx_valid & RX_IE)
//
// state    | meaning
// TX_IDLE  | line high, waiting for FIFO data
// TX_START | start bit (0), DIVISOR+1 clocks
// TX_DATA  | 8 data bits LSB first, DIVISOR+1 clocks each
// TX_STOP  | stop bit (1), then next frame or idle
// RX_IDLE  | waiting for falling edge on synchronized rxd
// RX_START | half-bit wait, confirm start bit still low
// RX_DATA  | sample 8 bits at bit centres
// RX_STOP  | sample stop bit, deliver byte if high
module apb_uart
  import uart_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TX_DEPTH    = 8,
  parameter int DEFAULT_DIV = 867
) (
  input  logic                  APB_PCLK,
  input  logic                  APB_PRESET,
  input  logic [ADDR_WIDTH-1:0] APB_paddr,
  input  logic [DATA_WIDTH-1:0] APB_pdata,
  output logic [DATA_WIDTH-1:0] APB_prdata,
  input  logic                  APB_psel,
  input  logic                  APB_penable,
  input  logic                  APB_pwrite,
  input  logic [3:0]            APB_pstb,
  output logic                  APB_pready,
  output logic                  APB_perr,
  output logic                  uart_txd,
  input  logic                  uart_rxd,
  output logic                  interrupt
);

  logic [15:0] div_q;
  logic        tx_ie, rx_ie;
  logic [7:0]  rx_byte;
  logic        rx_valid, rx_overrun;

  logic        tx_full, fifo_empty, tx_push, tx_pop;
  logic [7:0]  fifo_rdata;
  logic        tx_busy, tx_empty;

  // APB decode
  logic       access, addr_err, data_wr, bad, stall, wr_ok, rd_ok, rd_data;
  logic [1:0] reg_sel;
  logic [DATA_WIDTH-1:0] rdata;

  assign access   = APB_psel & APB_penable;
  assign reg_sel  = APB_paddr[3:2];
  assign addr_err = (APB_paddr[1:0] != 2'b00);
  assign data_wr  = access & APB_pwrite & (reg_sel == REG_DATA);
  assign bad      = addr_err | (data_wr & ~APB_pstb[0]);
  // A pop in the same cycle frees a slot, so the stalled push completes then.
  assign stall    = data_wr & ~bad & tx_full & ~tx_pop;
  assign wr_ok    = access & APB_pwrite & ~bad & ~stall;
  assign rd_ok    = access & ~APB_pwrite & ~bad;
  assign rd_data  = rd_ok & (reg_sel == REG_DATA);
  assign tx_push  = wr_ok & (reg_sel == REG_DATA);

  assign APB_pready = access & ~stall;
  assign APB_perr   = access & bad;

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_DATA:   rdata[7:0] = rx_byte;
      REG_STATUS: begin
        rdata[ST_TX_FULL]  = tx_full;
        rdata[ST_TX_EMPTY] = tx_empty;
        rdata[ST_RX_VALID] = rx_valid;
        rdata[ST_RX_OVR]   = rx_overrun;
        rdata[ST_TX_BUSY]  = tx_busy;
      end
      REG_DIV:    rdata[15:0] = div_q;
      REG_CTRL:   begin
        rdata[CTRL_TX_IE] = tx_ie;
        rdata[CTRL_RX_IE] = rx_ie;
      end
      default:    rdata = '0;
    endcase
  end

  assign APB_prdata = rd_ok ? rdata : '0;

  logic unused_bits;
  assign unused_bits = ^{APB_paddr[ADDR_WIDTH-1:4], APB_pdata[DATA_WIDTH-1:16], APB_pstb[3:1]};

  always_ff @(posedge APB_PCLK) begin
    if (APB_PRESET) begin
      div_q <= 16'(DEFAULT_DIV);
      tx_ie <= 1'b0;
      rx_ie <= 1'b0;
    end else if (wr_ok) begin
      if (reg_sel == REG_DIV) div_q <= APB_pdata[15:0];
      if (reg_sel == REG_CTRL) begin
        tx_ie <= APB_pdata[CTRL_TX_IE];
        rx_ie <= APB_pdata[CTRL_RX_IE];
      end
    end
  end

  uart_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk   (APB_PCLK),
    .rst   (APB_PRESET),
    .push  (tx_push),
    .wdata (APB_pdata[7:0]),
    .pop   (tx_pop),
    .rdata (fifo_rdata),
    .full  (tx_full),
    .empty (fifo_empty)
  );

  // TX
  tx_state_e   tx_state, tx_state_nxt;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_tc, txd_c;

  assign tx_tc    = (tx_cnt == 16'd0);
  assign tx_busy  = (tx_state != TX_IDLE);
  assign tx_empty = fifo_empty & ~tx_busy;
  assign uart_txd = txd_c;

  always_ff @(posedge APB_PCLK) begin
    if (APB_PRESET) tx_state <= TX_IDLE;
    else            tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_pop       = 1'b0;
    txd_c        = 1'b1;
    case (tx_state)
      TX_IDLE:  if (!fifo_empty) begin
        tx_state_nxt = TX_START;
        tx_pop       = 1'b1;
      end
      TX_START: begin
        txd_c = 1'b0;
        if (tx_tc) tx_state_nxt = TX_DATA;
      end
      TX_DATA:  begin
        txd_c = tx_shift[0];
        if (tx_tc && tx_bit == 3'd7) tx_state_nxt = TX_STOP;
      end
      TX_STOP:  if (tx_tc) begin
        if (!fifo_empty) begin
          tx_state_nxt = TX_START;
          tx_pop       = 1'b1;
        end else begin
          tx_state_nxt = TX_IDLE;
        end
      end
      default:  tx_state_nxt = TX_IDLE;
    endcase
  end

  // Bit timer reloads from DIVISOR at every bit boundary, so a new divisor
  // lands on the next bit rather than mid-bit.
  always_ff @(posedge APB_PCLK) begin
    if (APB_PRESET) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      if (tx_state_nxt != tx_state || (tx_state == TX_DATA && tx_tc)) tx_cnt <= div_q;
      else if (tx_state != TX_IDLE) tx_cnt <= tx_cnt - 16'd1;
      if (tx_pop) begin
        tx_shift <= fifo_rdata;
        tx_bit   <= 3'd0;
      end else if (tx_state == TX_DATA && tx_tc) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_bit   <= tx_bit + 3'd1;
      end
    end
  end

  // RX
  rx_state_e   rx_state, rx_state_nxt;
  logic        rx_s1, rx_s2, rx_d;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_tc, rx_good;
  logic [16:0] div_p1;
  logic [15:0] rx_half_m1;

  assign rx_tc      = (rx_cnt == 16'd0);
  assign div_p1     = {1'b0, div_q} + 17'd1;
  assign rx_half_m1 = div_p1[16:1] - 16'd1;

  always_ff @(posedge APB_PCLK) begin
    if (APB_PRESET) rx_state <= RX_IDLE;
    else            rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_good      = 1'b0;
    case (rx_state)
      RX_IDLE:  if (!rx_s2 && rx_d) rx_state_nxt = RX_START;
      RX_START: if (rx_tc) rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tc && rx_bit == 3'd7) rx_state_nxt = RX_STOP;
      RX_STOP:  if (rx_tc) begin
        rx_state_nxt = RX_IDLE;
        rx_good      = rx_s2;
      end
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge APB_PCLK) begin
    if (APB_PRESET) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_d       <= 1'b1;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_s1 <= uart_rxd;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
      if (rx_state == RX_IDLE) rx_cnt <= rx_half_m1;
      else if (rx_tc)          rx_cnt <= div_q;
      else                     rx_cnt <= rx_cnt - 16'd1;
      if (rx_state == RX_START) rx_bit <= 3'd0;
      else if (rx_state == RX_DATA && rx_tc) begin
        rx_bit   <= rx_bit + 3'd1;
        rx_shift <= {rx_s2, rx_shift[7:1]};
      end
      // A same-cycle DATA read consumes the old byte, so the new one may load.
      if (rx_good && !(rx_valid && !rd_data)) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rd_data) begin
        rx_valid <= 1'b0;
      end
      if (rx_good && rx_valid && !rd_data) rx_overrun <= 1'b1;
      else if (wr_ok && reg_sel == REG_CTRL && APB_pdata[CTRL_CLR_OVR]) rx_overrun <= 1'b0;
    end
  end

  assign interrupt = (tx_empty & tx_ie) | (rx_valid & rx_ie);

endmodule

// File: tb/tb_apb_uart.sv
// tb_apb_uart: directed self-checking bench for apb_uart.
module tb_apb_uart;

  logic        APB_PCLK = 1'b0;
  logic        APB_PRESET;
  logic [31:0] APB_paddr;
  logic [31:0] APB_pdata;
  logic [31:0] APB_prdata;
  logic        APB_psel, APB_penable, APB_pwrite;
  logic [3:0]  APB_pstb;
  logic        APB_pready, APB_perr;
  logic        uart_txd, uart_rxd, interrupt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 APB_PCLK = ~APB_PCLK;

  apb_uart dut (
    .APB_PCLK    (APB_PCLK),
    .APB_PRESET  (APB_PRESET),
    .APB_paddr   (APB_paddr),
    .APB_pdata   (APB_pdata),
    .APB_prdata  (APB_prdata),
    .APB_psel    (APB_psel),
    .APB_penable (APB_penable),
    .APB_pwrite  (APB_pwrite),
    .APB_pstb    (APB_pstb),
    .APB_pready  (APB_pready),
    .APB_perr    (APB_perr),
    .uart_txd    (uart_txd),
    .uart_rxd    (uart_rxd),
    .interrupt   (interrupt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic err, output int stall);
    @(negedge APB_PCLK);
    APB_psel = 1'b1; APB_penable = 1'b0; APB_pwrite = wr;
    APB_paddr = addr; APB_pdata = wdata; APB_pstb = strb;
    @(negedge APB_PCLK);
    APB_penable = 1'b1;
    stall = 0;
    #1;
    while (!APB_pready && stall < 300) begin
      @(negedge APB_PCLK); #1;
      stall++;
    end
    if (stall >= 300) check("pready_timeout", APB_pready, 1);
    rdata = APB_prdata;
    err   = APB_perr;
    @(posedge APB_PCLK); #1;
    APB_psel = 1'b0; APB_penable = 1'b0; APB_pwrite = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] r; logic e; int s;
    apb_xfer(1'b1, addr, data, 4'hF, r, e, s);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] r; logic e; int s;
    apb_xfer(1'b0, addr, 32'h0, 4'hF, r, e, s);
    check(tag, r, exp);
  endtask

  // Samples uart_txd every clock across one full frame of 10*per clocks.
  task automatic tx_frame(input logic [7:0] b, input int per, input logic wait_start, input string tag);
    logic [9:0] fr;
    int t;
    fr = {1'b1, b, 1'b0};
    if (wait_start) begin
      t = 0;
      @(negedge APB_PCLK);
      while (uart_txd !== 1'b0 && t < 3000) begin
        @(negedge APB_PCLK);
        t++;
      end
      check({tag, "_start"}, uart_txd, 0);
    end else begin
      @(negedge APB_PCLK);
    end
    for (int k = 0; k < 10 * per; k++) begin
      if (k > 0) @(negedge APB_PCLK);
      check(tag, uart_txd, fr[k / per]);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input int per);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < per; j++) begin
        @(negedge APB_PCLK);
        uart_rxd = fr[k];
      end
    repeat (4) @(negedge APB_PCLK);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r; logic e; int s;
    APB_PRESET = 1'b1; APB_psel = 1'b0; APB_penable = 1'b0; APB_pwrite = 1'b0;
    APB_paddr = '0; APB_pdata = '0; APB_pstb = '0; uart_rxd = 1'b1;
    repeat (3) @(posedge APB_PCLK);
    @(negedge APB_PCLK);
    APB_PRESET = 1'b0;

    // Reset state
    check("rst_txd", uart_txd, 1);
    check("rst_irq", interrupt, 0);
    check("rst_pready_idle", APB_pready, 0);
    apb_xfer(1'b0, 32'h4, 32'h0, 4'hF, r, e, s);
    check("t1_status", r, 32'h02);
    check("t1_first_pready", s, 0);
    check("t1_perr", e, 0);
    rd_chk("t1_div", 32'h8, 32'd867);
    rd_chk("t1_data_empty", 32'h0, 32'h0);
    rd_chk("t1_ctrl", 32'hC, 32'h0);
    wr(32'h8, 32'hFFF1_2345);
    rd_chk("div_upper_zero", 32'h8, 32'h2345);
    wr(32'hC, 32'h1);
    check("irq_tx_empty", interrupt, 1);
    rd_chk("ctrl_rd", 32'hC, 32'h1);
    wr(32'hC, 32'h0);
    check("irq_off", interrupt, 0);

    // Single frame, divisor 3
    wr(32'h8, 32'd3);
    wr(32'h0, 32'h55);
    tx_frame(8'h55, 4, 1'b1, "t2_txd");
    rd_chk("t2_status_idle", 32'h4, 32'h02);

    // Divisor 0: one clock per bit
    wr(32'h8, 32'd0);
    wr(32'h0, 32'hC5);
    tx_frame(8'hC5, 1, 1'b1, "div0_txd");
    rd_chk("div0_status", 32'h4, 32'h02);

    // Burst of 10 writes: FIFO fills on the 9th, the 10th stalls
    wr(32'h8, 32'd3);
    fork
      begin
        logic [31:0] rr; logic ee; int ss;
        for (int i = 0; i < 9; i++) wr(32'h0, 32'(8'h11 * (i + 1)));
        rd_chk("t3_status_full", 32'h4, 32'h11);
        apb_xfer(1'b1, 32'h0, 32'hA5, 4'hF, rr, ee, ss);
        check("t3_stalled", (ss > 0), 1);
        check("t3_stall_perr", ee, 0);
      end
      begin
        tx_frame(8'h11, 4, 1'b1, "t3_f0");
        for (int i = 1; i < 9; i++) tx_frame(8'(8'h11 * (i + 1)), 4, 1'b0, "t3_fn");
        tx_frame(8'hA5, 4, 1'b0, "t3_f9");
      end
    join
    rd_chk("t3_status_done", 32'h4, 32'h02);

    // RX
    wr(32'h8, 32'd7);
    wr(32'hC, 32'h2);
    send_rx(8'hA3, 8);
    check("t4_irq_rx", interrupt, 1);
    rd_chk("t4_status_valid", 32'h4, 32'h06);
    rd_chk("t4_data", 32'h0, 32'hA3);
    rd_chk("t4_status_clr", 32'h4, 32'h02);
    check("t4_irq_clr", interrupt, 0);
    send_rx(8'h3C, 8);
    send_rx(8'h5A, 8);
    rd_chk("t4_status_ovr", 32'h4, 32'h0E);
    rd_chk("t4_data_old", 32'h0, 32'h3C);
    rd_chk("t4_status_ovr_kept", 32'h4, 32'h0A);
    wr(32'hC, 32'h4);
    rd_chk("t4_status_ovr_clr", 32'h4, 32'h02);
    rd_chk("t4_ctrl_bit2_zero", 32'hC, 32'h0);

    // Error responses
    send_rx(8'h96, 8);
    apb_xfer(1'b0, 32'h2, 32'h0, 4'hF, r, e, s);
    check("t5_mis_pready", s, 0);
    check("t5_mis_perr", e, 1);
    check("t5_mis_prdata", r, 0);
    rd_chk("t5_status_kept", 32'h4, 32'h06);
    apb_xfer(1'b1, 32'h0, 32'h77, 4'b1110, r, e, s);
    check("t5_strb_perr", e, 1);
    check("t5_strb_pready", s, 0);
    repeat (3) @(negedge APB_PCLK);
    check("t5_txd_idle", uart_txd, 1);
    rd_chk("t5_status_fifo", 32'h4, 32'h06);
    rd_chk("t5_data", 32'h0, 32'h96);

    // Reset mid-frame
    wr(32'hC, 32'h3);
    wr(32'h0, 32'h00);
    wr(32'h0, 32'h00);
    begin
      int t = 0;
      while (uart_txd !== 1'b0 && t < 200) begin
        @(negedge APB_PCLK);
        t++;
      end
    end
    repeat (10) @(negedge APB_PCLK);
    check("t6_midframe_low", uart_txd, 0);
    APB_PRESET = 1'b1;
    @(negedge APB_PCLK);
    check("t6_txd_after_rst", uart_txd, 1);
    check("t6_irq_after_rst", interrupt, 0);
    APB_PRESET = 1'b0;
    rd_chk("t6_status", 32'h4, 32'h02);
    rd_chk("t6_ctrl", 32'hC, 32'h0);
    rd_chk("t6_div", 32'h8, 32'd867);

    // Glitch reject, then a real byte still received
    wr(32'h8, 32'd7);
    wr(32'hC, 32'h2);
    @(negedge APB_PCLK); uart_rxd = 1'b0;
    @(negedge APB_PCLK);
    @(negedge APB_PCLK); uart_rxd = 1'b1;
    repeat (20) @(negedge APB_PCLK);
    rd_chk("t6_glitch_status", 32'h4, 32'h02);
    check("t6_glitch_irq", interrupt, 0);
    send_rx(8'h4B, 8);
    rd_chk("t6_after_glitch_status", 32'h4, 32'h06);
    rd_chk("t6_after_glitch_data", 32'h0, 32'h4B);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
